noc_local_endpoint: RTL and testbench
=====================================

Name: noc_local_endpoint

Overview:
- Network interface that attaches to a router's local (L) port and implements the far end of the credit-based link protocol.
- TX side formats local requests into 16-bit flits and injects them into the router's local input port. It injects only while it holds credits, and each credit pulse from the router returns one credit.
- RX side accepts flits from the router's local output port into a buffer. It returns one credit pulse to the router for every flit consumed locally.
- One endpoint per mesh node; XCOORD/YCOORD match the attached router.

Parameters:
- XCOORD, 0, this node's X coordinate, 4 bits.
- YCOORD, 0, this node's Y coordinate, 4 bits.
- TX_CREDITS, 4, initial credit count; equals the depth of the router's local input FIFO.
- TXQ_DEPTH, 2, local request queue depth; power of 2, at least 2.
- RXQ_DEPTH, 4, RX buffer depth; equals the credits the router's local output port starts with.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  local send request.
- req_ready_o  out  1  TX queue not full; request accepted when valid and ready are both high.
- req_dest_x_i  in  4  destination X coordinate.
- req_dest_y_i  in  4  destination Y coordinate.
- req_payload_i  in  8  payload byte.
- tx_data_o  out  16  flit to the router's local input port.
- tx_enable_o  out  1  flit valid, one-cycle pulse per flit.
- tx_credit_i  in  1  credit return pulse from the router.
- rx_data_i  in  16  flit from the router's local output port.
- rx_enable_i  in  1  rx_data_i valid.
- rx_credit_o  out  1  credit return pulse to the router.
- rx_valid_o  out  1  RX buffer not empty.
- rx_ready_i  in  1  local consumer pops the RX head.
- rx_payload_o  out  8  payload of the RX head flit.
- rx_src_ok_o  out  1  the head flit's destination matches XCOORD/YCOORD.
- err_o  out  3  sticky errors: bit0 credit overflow, bit1 RX overflow, bit2 misroute.

Behaviour:
- Reset values (synchronous rst):
  - credit counter = TX_CREDITS; both queues empty.
  - tx_enable_o = 0, tx_data_o = 0, rx_credit_o = 0, rx_valid_o = 0, err_o = 0.
  - req_ready_o = 1 in the cycle after rst deasserts.
  - Reset mid-packet discards all queued flits and in-flight credits without error.
- Flit format:
  - [15:8] payload.
  - [7:4] destination X.
  - [3:0] destination Y.
  - The router routes on [7:0].
- TX path:
  - An accepted request is written to the TX queue that cycle.
  - Send condition: queue not empty and credit counter > 0.
  - On send, the next cycle presents tx_enable_o = 1 with tx_data_o = head flit (registered output). The same edge pops the head and decrements credits.
  - At most one flit per cycle; back-to-back sends are allowed while credits remain.
  - Minimum latency from accept to tx_enable_o is 2 cycles when the queue was empty.
  - tx_data_o holds its last value while tx_enable_o = 0.
  - Credit counter width is clog2(TX_CREDITS+1).
  - Send and tx_credit_i in the same cycle: counter unchanged.
  - tx_credit_i while the counter equals TX_CREDITS and no send occurs: counter saturates and err_o[0] is set.
  - Counter = 0: no send; queue holds; req_ready_o drops once the queue is full.
- TX state machine, 2 states:
  - IDLE: queue empty or credits = 0; go to SEND when the send condition holds.
  - SEND: a flit was issued this cycle; stay in SEND while the send condition still holds after the update, else return to IDLE.
- RX path:
  - rx_enable_i = 1 writes rx_data_i to the RX buffer that cycle.
  - rx_valid_o, rx_payload_o and rx_src_ok_o reflect the buffer head; the first write is visible 1 cycle after rx_enable_i.
  - Pop when rx_valid_o and rx_ready_i are both high.
  - rx_credit_o pulses high exactly 1 cycle after each pop (registered); one pulse per pop.
  - Simultaneous write and pop: both happen; occupancy unchanged.
  - Write into a full buffer without a simultaneous pop: flit dropped, err_o[1] set. This is a protocol violation by the router.
  - A flit whose [7:4]/[3:0] differ from XCOORD/YCOORD is still delivered with rx_src_ok_o = 0, and err_o[2] is set when it is pushed.
- Error bits clear only on rst.

Decomposition:
- Package noc_pkg holds:
  - flit_t, a packed struct {payload[7:0], dst_x[3:0], dst_y[3:0]}.
  - FLIT_W = 16 and COORD_W = 4.
  - Error-bit index constants ERR_CREDIT = 0, ERR_RXOVF = 1, ERR_MISROUTE = 2.
- Sub-module noc_sync_fifo:
  - Parameterized width and depth, registered pointers, full/empty outputs.
  - Instantiated twice: TX queue (TXQ_DEPTH) and RX buffer (RXQ_DEPTH).
- Credit counter, TX state machine and RX credit pulse register live in the top module.

Test Plan:
1. Reset, then one request with dest (2,3) and payload 0xA5 → tx_enable_o pulses 2 cycles after accept with tx_data_o = 0xA523; credits go 4→3.
2. Six back-to-back requests with tx_credit_i held 0 → exactly 4 flits sent on consecutive cycles, then stall; req_ready_o = 0 once the queue holds 2. One tx_credit_i pulse → exactly one more flit follows.
3. tx_credit_i on the same cycle as a send → counter unchanged. tx_credit_i with the counter at 4 and idle → counter stays 4, err_o = 3'b001.
4. rx_enable_i with flit 0x5A00 at node (0,0), rx_ready_i = 1 → rx_valid_o and rx_payload_o = 0x5A after 1 cycle; rx_credit_o pulses 1 cycle after the pop; rx_src_ok_o = 1.
5. Five RX writes with rx_ready_i = 0 → the fifth flit is dropped and err_o[1] set. Then draining with rx_ready_i = 1 → 4 payloads in order and 4 rx_credit_o pulses.
6. rst asserted with 2 flits queued and 1 credit outstanding → next cycle credits = 4, queues empty, all outputs at reset values; a fresh request sends normally.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit layout, widths and error-bit indices for the NoC endpoint
package noc_pkg;
  localparam int FLIT_W = 16;
  localparam int COORD_W = 4;
  localparam int ERR_CREDIT = 0;
  localparam int ERR_RXOVF = 1;
  localparam int ERR_MISROUTE = 2;
  typedef struct packed {
    logic [7:0] payload;
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
  } flit_t;
endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: synchronous FIFO with combinational head read and registered pointers
module noc_sync_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_wr, do_rd;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign rd_data = mem[rd_ptr];
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  // pointer/occupancy update; a write into a full FIFO only lands when a pop frees the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr <= nxt(wr_ptr);
      end
      if (do_rd) rd_ptr <= nxt(rd_ptr);
      count <= count + (AW + 1)'(do_wr) - (AW + 1)'(do_rd);
    end
  end
endmodule

// File: rtl/noc_local_endpoint.sv
// noc_local_endpoint: credit-based network interface on a router's local port
module noc_local_endpoint
  import noc_pkg::*;
#(
  parameter int XCOORD = 0,
  parameter int YCOORD = 0,
  parameter int TX_CREDITS = 4,
  parameter int TXQ_DEPTH = 2,
  parameter int RXQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [COORD_W-1:0] req_dest_x_i,
  input  logic [COORD_W-1:0] req_dest_y_i,
  input  logic [7:0]        req_payload_i,
  output logic [FLIT_W-1:0] tx_data_o,
  output logic              tx_enable_o,
  input  logic              tx_credit_i,
  input  logic [FLIT_W-1:0] rx_data_i,
  input  logic              rx_enable_i,
  output logic              rx_credit_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic [7:0]        rx_payload_o,
  output logic              rx_src_ok_o,
  output logic [2:0]        err_o
);
  localparam int CW = $clog2(TX_CREDITS + 1);
  typedef enum logic {IDLE, SEND} tx_state_t;
  tx_state_t state;
  logic [CW-1:0] credits;
  flit_t req_flit, tx_head, rx_head, rx_in;
  logic tx_full, tx_empty, rx_full, rx_empty, send, rx_pop, rx_push, credit_max;
  assign req_flit = '{payload: req_payload_i, dst_x: req_dest_x_i, dst_y: req_dest_y_i};
  assign rx_in = rx_data_i;
  assign req_ready_o = !tx_full;
  assign credit_max = credits == CW'(TX_CREDITS);
  assign send = !tx_empty && credits != '0;
  assign tx_enable_o = state == SEND;
  assign rx_valid_o = !rx_empty;
  assign rx_pop = rx_valid_o && rx_ready_i;
  assign rx_push = rx_enable_i && (!rx_full || rx_pop);
  assign rx_payload_o = rx_head.payload;
  assign rx_src_ok_o = rx_head.dst_x == COORD_W'(XCOORD) && rx_head.dst_y == COORD_W'(YCOORD);
  noc_sync_fifo #(.W(FLIT_W), .DEPTH(TXQ_DEPTH)) u_txq (
    .clk(clk), .rst(rst), .wr_en(req_valid_i && req_ready_o), .wr_data(req_flit),
    .rd_en(send), .rd_data(tx_head), .full(tx_full), .empty(tx_empty)
  );
  noc_sync_fifo #(.W(FLIT_W), .DEPTH(RXQ_DEPTH)) u_rxq (
    .clk(clk), .rst(rst), .wr_en(rx_enable_i), .wr_data(rx_data_i),
    .rd_en(rx_pop), .rd_data(rx_head), .full(rx_full), .empty(rx_empty)
  );
  // TX state machine: issue the head flit when credits allow; a credit arriving with a send cancels out
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx_data_o <= '0;
      credits <= CW'(TX_CREDITS);
    end else begin
      state <= send ? SEND : IDLE;
      if (send) tx_data_o <= tx_head;
      credits <= send && !tx_credit_i ? credits - 1'b1 :
                 !send && tx_credit_i && !credit_max ? credits + 1'b1 : credits;
    end
  end
  // RX credit return pulse and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_credit_o <= 1'b0;
      err_o <= '0;
    end else begin
      rx_credit_o <= rx_pop;
      err_o[ERR_CREDIT] <= err_o[ERR_CREDIT] | (tx_credit_i && !send && credit_max);
      err_o[ERR_RXOVF] <= err_o[ERR_RXOVF] | (rx_enable_i && !rx_push);
      err_o[ERR_MISROUTE] <= err_o[ERR_MISROUTE] |
        (rx_push && (rx_in.dst_x != COORD_W'(XCOORD) || rx_in.dst_y != COORD_W'(YCOORD)));
    end
  end
endmodule

// File: tb/tb_noc_local_endpoint.sv
// tb_noc_local_endpoint: directed vector table plus hand sequences for credit and reset corners
module tb_noc_local_endpoint;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid_i = 1'b0, req_ready_o;
  logic [3:0] req_dest_x_i = '0, req_dest_y_i = '0;
  logic [7:0] req_payload_i = '0;
  logic [15:0] tx_data_o;
  logic tx_enable_o, tx_credit_i = 1'b0;
  logic [15:0] rx_data_i = '0;
  logic rx_enable_i = 1'b0, rx_credit_o, rx_valid_o, rx_ready_i = 1'b0;
  logic [7:0] rx_payload_o;
  logic rx_src_ok_o;
  logic [2:0] err_o;
  int checks = 0, failures = 0;
  logic [15:0] got[$];
  int got_cyc[$];
  noc_local_endpoint dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_dest_x_i(req_dest_x_i), .req_dest_y_i(req_dest_y_i), .req_payload_i(req_payload_i),
    .tx_data_o(tx_data_o), .tx_enable_o(tx_enable_o), .tx_credit_i(tx_credit_i),
    .rx_data_i(rx_data_i), .rx_enable_i(rx_enable_i), .rx_credit_o(rx_credit_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_payload_o(rx_payload_o),
    .rx_src_ok_o(rx_src_ok_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] ctl_in;
    logic [15:0] req;
    logic [15:0] rd;
    logic [3:0] ctl_out;
    logic [15:0] e_txd;
    logic [7:0] e_pl;
    logic e_ok;
    logic [2:0] e_err;
  } vec_t;
  vec_t tab[18];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    req_valid_i = 1'b0;
    tx_credit_i = 1'b0;
    rx_enable_i = 1'b0;
    rx_ready_i = 1'b0;
  endtask
  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask
  task automatic chk_reset(input string n);
    chk({n, ".credits"}, 32'(dut.credits), 32'd4);
    chk({n, ".txen"}, 32'(tx_enable_o), 32'd0);
    chk({n, ".txd"}, 32'(tx_data_o), 32'h0);
    chk({n, ".rdy"}, 32'(req_ready_o), 32'd1);
    chk({n, ".rxv"}, 32'(rx_valid_o), 32'd0);
    chk({n, ".rxc"}, 32'(rx_credit_o), 32'd0);
    chk({n, ".err"}, 32'(err_o), 32'd0);
  endtask
  task automatic burst6(output int acc);
    logic a;
    acc = 0;
    got.delete();
    got_cyc.delete();
    for (int c = 0; c < 12; c++) begin
      req_valid_i = acc < 6;
      req_payload_i = 8'h10 + 8'(acc);
      req_dest_x_i = 4'h1;
      req_dest_y_i = 4'(acc);
      a = req_valid_i && req_ready_o;
      step();
      if (a) acc++;
      if (tx_enable_o) begin
        got.push_back(tx_data_o);
        got_cyc.push_back(c);
      end
    end
    req_valid_i = 1'b0;
  endtask
  initial begin
    int acc;
    vec_t v;
    tab[0]  = '{4'b1000, 16'hA523, 16'h0000, 4'b0100, 16'h0000, 8'h00, 1'b0, 3'h0};
    tab[1]  = '{4'b0000, 16'h0000, 16'h0000, 4'b1100, 16'hA523, 8'h00, 1'b0, 3'h0};
    tab[2]  = '{4'b0000, 16'h0000, 16'h0000, 4'b0100, 16'hA523, 8'h00, 1'b0, 3'h0};
    tab[3]  = '{4'b0011, 16'h0000, 16'h5A00, 4'b0110, 16'hA523, 8'h5A, 1'b1, 3'h0};
    tab[4]  = '{4'b0001, 16'h0000, 16'h0000, 4'b0101, 16'hA523, 8'h00, 1'b0, 3'h0};
    tab[5]  = '{4'b0000, 16'h0000, 16'h0000, 4'b0100, 16'hA523, 8'h00, 1'b0, 3'h0};
    tab[6]  = '{4'b0010, 16'h0000, 16'h1100, 4'b0110, 16'hA523, 8'h11, 1'b1, 3'h0};
    tab[7]  = '{4'b0010, 16'h0000, 16'h2200, 4'b0110, 16'hA523, 8'h11, 1'b1, 3'h0};
    tab[8]  = '{4'b0010, 16'h0000, 16'h3300, 4'b0110, 16'hA523, 8'h11, 1'b1, 3'h0};
    tab[9]  = '{4'b0010, 16'h0000, 16'h4400, 4'b0110, 16'hA523, 8'h11, 1'b1, 3'h0};
    tab[10] = '{4'b0010, 16'h0000, 16'h5500, 4'b0110, 16'hA523, 8'h11, 1'b1, 3'h2};
    tab[11] = '{4'b0001, 16'h0000, 16'h0000, 4'b0111, 16'hA523, 8'h22, 1'b1, 3'h2};
    tab[12] = '{4'b0001, 16'h0000, 16'h0000, 4'b0111, 16'hA523, 8'h33, 1'b1, 3'h2};
    tab[13] = '{4'b0001, 16'h0000, 16'h0000, 4'b0111, 16'hA523, 8'h44, 1'b1, 3'h2};
    tab[14] = '{4'b0001, 16'h0000, 16'h0000, 4'b0101, 16'hA523, 8'h00, 1'b0, 3'h2};
    tab[15] = '{4'b0000, 16'h0000, 16'h0000, 4'b0100, 16'hA523, 8'h00, 1'b0, 3'h2};
    tab[16] = '{4'b0010, 16'h0000, 16'h7712, 4'b0110, 16'hA523, 8'h77, 1'b0, 3'h6};
    tab[17] = '{4'b0001, 16'h0000, 16'h0000, 4'b0101, 16'hA523, 8'h00, 1'b0, 3'h6};
    do_reset();
    chk_reset("rst0");
    for (int i = 0; i < 18; i++) begin
      v = tab[i];
      {req_valid_i, tx_credit_i, rx_enable_i, rx_ready_i} = v.ctl_in;
      {req_payload_i, req_dest_x_i, req_dest_y_i} = v.req;
      rx_data_i = v.rd;
      step();
      chk($sformatf("v%0d.txen", i), 32'(tx_enable_o), 32'(v.ctl_out[3]));
      chk($sformatf("v%0d.txd", i), 32'(tx_data_o), 32'(v.e_txd));
      chk($sformatf("v%0d.rdy", i), 32'(req_ready_o), 32'(v.ctl_out[2]));
      chk($sformatf("v%0d.rxv", i), 32'(rx_valid_o), 32'(v.ctl_out[1]));
      chk($sformatf("v%0d.rxc", i), 32'(rx_credit_o), 32'(v.ctl_out[0]));
      chk($sformatf("v%0d.err", i), 32'(err_o), 32'(v.e_err));
      if (v.ctl_out[1]) begin
        chk($sformatf("v%0d.pl", i), 32'(rx_payload_o), 32'(v.e_pl));
        chk($sformatf("v%0d.ok", i), 32'(rx_src_ok_o), 32'(v.e_ok));
      end
    end
    idle_in();
    chk("t1.credits", 32'(dut.credits), 32'd3);
    do_reset();
    burst6(acc);
    chk("t2.accepted", 32'(acc), 32'd6);
    chk("t2.nflits", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) begin
      chk($sformatf("t2.flit%0d", i), 32'(got[i]), 32'({8'h10 + 8'(i), 4'h1, 4'(i)}));
      chk($sformatf("t2.cyc%0d", i), 32'(got_cyc[i]), 32'(got_cyc[0] + i));
    end
    chk("t2.rdy_full", 32'(req_ready_o), 32'd0);
    chk("t2.credits0", 32'(dut.credits), 32'd0);
    tx_credit_i = 1'b1;
    step();
    tx_credit_i = 1'b0;
    got.delete();
    for (int c = 0; c < 5; c++) begin
      step();
      if (tx_enable_o) got.push_back(tx_data_o);
    end
    chk("t2.one_more", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("t2.flit4", 32'(got[0]), 32'h1414);
    chk("t2.rdy_again", 32'(req_ready_o), 32'd1);
    tx_credit_i = 1'b1;
    step();
    chk("t3.pre_credits", 32'(dut.credits), 32'd1);
    step();
    tx_credit_i = 1'b0;
    chk("t3.same_txen", 32'(tx_enable_o), 32'd1);
    chk("t3.same_txd", 32'(tx_data_o), 32'h1515);
    chk("t3.same_credits", 32'(dut.credits), 32'd1);
    step();
    chk("t3.no_err", 32'(err_o), 32'd0);
    do_reset();
    tx_credit_i = 1'b1;
    step();
    tx_credit_i = 1'b0;
    step();
    chk("t3.sat_credits", 32'(dut.credits), 32'd4);
    chk("t3.sat_err", 32'(err_o), 32'd1);
    chk("t3.sat_txen", 32'(tx_enable_o), 32'd0);
    do_reset();
    burst6(acc);
    tx_credit_i = 1'b1;
    rx_enable_i = 1'b1;
    rx_data_i = 16'h6600;
    step();
    idle_in();
    rst = 1'b1;
    step();
    chk_reset("t6.rst");
    rst = 1'b0;
    step();
    chk("t6.q_empty_txen", 32'(tx_enable_o), 32'd0);
    chk("t6.rxv", 32'(rx_valid_o), 32'd0);
    req_valid_i = 1'b1;
    req_payload_i = 8'hC3;
    req_dest_x_i = 4'h2;
    req_dest_y_i = 4'h3;
    step();
    req_valid_i = 1'b0;
    chk("t6.acc_txen", 32'(tx_enable_o), 32'd0);
    step();
    chk("t6.txen", 32'(tx_enable_o), 32'd1);
    chk("t6.txd", 32'(tx_data_o), 32'hC323);
    chk("t6.credits", 32'(dut.credits), 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
